// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module : fifo_burst_reader
// Brief  : Drains a showahead FIFO into sop/eop-framed bursts on a valid/ready
//          stream, with timeout- or request-driven flush of partial bursts.
// Rev    : 1.0 - initial release
// ============================================================================
module fifo_burst_reader #(
    parameter int DWIDTH    = 4,
    parameter int AWIDTH    = 7,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 8
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] fifo_q_i,
    input  logic              fifo_empty_i,
    input  logic [AWIDTH:0]   fifo_usedw_i,
    output logic              fifo_rdreq_o,
    input  logic              flush_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              sop_o,
    output logic              eop_o,
    output logic              busy_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int              c_TMO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [AWIDTH:0] c_TMO_LAST   = c_TMO_LAST_I[AWIDTH:0];
    localparam logic [AWIDTH:0] c_BURST_LEN  = BURST_LEN[AWIDTH:0];
    localparam logic [AWIDTH:0] c_ONE        = {{AWIDTH{1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AWIDTH:0]   r_remaining;
    logic [AWIDTH:0]   w_remaining_nxt;
    logic [AWIDTH:0]   r_timer;
    logic [AWIDTH:0]   w_timer_nxt;
    logic              r_first;
    logic              w_first_nxt;
    logic              r_flush_pending;
    logic              w_flush_pending_nxt;

    logic [DWIDTH-1:0] r_data;
    logic              r_valid;
    logic              r_sop;
    logic              r_eop;

    logic              w_load;
    logic              w_pop;
    logic              w_full_start;
    logic              w_timeout_hit;
    logic              w_flush_start;

    assign w_load        = !r_valid | ready_i;
    assign w_pop         = (r_state == ST_RUN) & w_load & !fifo_empty_i;
    assign w_full_start  = (fifo_usedw_i >= c_BURST_LEN);
    assign w_timeout_hit = (TIMEOUT != 0) && (r_timer == c_TMO_LAST);
    assign w_flush_start = !fifo_empty_i & (r_flush_pending | w_timeout_hit);

    always_comb begin
        w_state_nxt         = r_state;
        w_remaining_nxt     = r_remaining;
        w_timer_nxt         = r_timer;
        w_first_nxt         = r_first;
        w_flush_pending_nxt = r_flush_pending | flush_i;
        case (r_state)
            ST_IDLE: begin
                if (fifo_empty_i) begin
                    // Nothing to flush: a pending request is discarded here.
                    w_timer_nxt         = '0;
                    w_flush_pending_nxt = 1'b0;
                end else if (w_full_start) begin
                    w_state_nxt     = ST_RUN;
                    w_remaining_nxt = c_BURST_LEN;
                    w_timer_nxt     = '0;
                    w_first_nxt     = 1'b1;
                end else if (w_flush_start) begin
                    w_state_nxt         = ST_RUN;
                    w_remaining_nxt     = fifo_usedw_i;
                    w_timer_nxt         = '0;
                    w_first_nxt         = 1'b1;
                    w_flush_pending_nxt = flush_i;
                end else if (r_timer < c_TMO_LAST) begin
                    w_timer_nxt = r_timer + c_ONE;
                end
            end
            ST_RUN: begin
                if (w_pop) begin
                    w_remaining_nxt = r_remaining - c_ONE;
                    w_first_nxt     = 1'b0;
                    if (r_remaining == c_ONE) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state         <= ST_IDLE;
            r_remaining     <= '0;
            r_timer         <= '0;
            r_first         <= 1'b0;
            r_flush_pending <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_remaining     <= w_remaining_nxt;
            r_timer         <= w_timer_nxt;
            r_first         <= w_first_nxt;
            r_flush_pending <= w_flush_pending_nxt;
        end
    end

    // Output register: data and framing move together, frozen while stalled.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
        end else if (w_load) begin
            r_valid <= w_pop;
            if (w_pop) begin
                r_data <= fifo_q_i;
                r_sop  <= r_first;
                r_eop  <= (r_remaining == c_ONE);
            end else begin
                r_sop  <= 1'b0;
                r_eop  <= 1'b0;
            end
        end
    end

    assign fifo_rdreq_o = w_pop;
    assign data_o       = r_data;
    assign valid_o      = r_valid;
    assign sop_o        = r_sop;
    assign eop_o        = r_eop;
    assign busy_o       = (r_state == ST_RUN) | r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module : tb_fifo_burst_reader
// Brief  : Self-checking bench for fifo_burst_reader with a FIFO model and a
//          stream-level scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_reader;

    localparam int DWIDTH    = 4;
    localparam int AWIDTH    = 7;
    localparam int BURST_LEN = 4;
    localparam int TIMEOUT   = 8;

    logic              clk        = 1'b0;
    logic              srst       = 1'b1;
    logic [DWIDTH-1:0] fifo_q     = '0;
    logic              fifo_empty = 1'b1;
    logic [AWIDTH:0]   fifo_usedw = '0;
    logic              fifo_rdreq;
    logic              flush      = 1'b0;
    logic              ready      = 1'b0;
    logic [DWIDTH-1:0] data;
    logic              valid, sop, eop, busy;
    logic              wr_en      = 1'b0;
    logic [DWIDTH-1:0] wr_data    = '0;

    // Second instance with the timeout disabled, fed a static one-word FIFO.
    logic [DWIDTH-1:0] z_q     = 4'h5;
    logic              z_empty = 1'b0;
    logic [AWIDTH:0]   z_usedw = 8'd1;
    logic              z_flush = 1'b0;
    logic              z_rdreq, z_valid, z_sop, z_eop, z_busy;
    logic [DWIDTH-1:0] z_data;
    logic              z_watch = 1'b1;
    logic              z_seen  = 1'b0;

    int total = 0;
    int bad   = 0;
    int nbursts  = 0;
    int last_len = 0;

    logic [DWIDTH-1:0] fq[$];
    logic [DWIDTH-1:0] exp_q[$];

    typedef struct {
        logic              wr;
        logic [DWIDTH-1:0] wd;
        logic              rdy;
        logic              e_valid;
        logic [DWIDTH-1:0] e_data;
        logic              e_sop;
        logic              e_eop;
        logic              e_rdreq;
        logic              e_busy;
    } vec_t;

    vec_t tv[11];

    fifo_burst_reader #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)) u_dut (
        .clk_i(clk), .srst_i(srst), .fifo_q_i(fifo_q), .fifo_empty_i(fifo_empty),
        .fifo_usedw_i(fifo_usedw), .fifo_rdreq_o(fifo_rdreq), .flush_i(flush),
        .data_o(data), .valid_o(valid), .ready_i(ready), .sop_o(sop), .eop_o(eop), .busy_o(busy)
    );

    fifo_burst_reader #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .BURST_LEN(BURST_LEN), .TIMEOUT(0)) u_dut0 (
        .clk_i(clk), .srst_i(srst), .fifo_q_i(z_q), .fifo_empty_i(z_empty),
        .fifo_usedw_i(z_usedw), .fifo_rdreq_o(z_rdreq), .flush_i(z_flush),
        .data_o(z_data), .valid_o(z_valid), .ready_i(1'b1), .sop_o(z_sop), .eop_o(z_eop), .busy_o(z_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    task automatic cyc(input logic rdy, input logic fl, input logic we, input logic [DWIDTH-1:0] wd);
        @(negedge clk);
        ready   = rdy;
        flush   = fl;
        wr_en   = we;
        wr_data = wd;
        #1;
    endtask

    function automatic vec_t mk(input logic wr, input logic [DWIDTH-1:0] wd, input logic ev,
                                input logic [DWIDTH-1:0] ed, input logic es, input logic ee,
                                input logic er, input logic eb);
        vec_t v;
        v.wr = wr; v.wd = wd; v.rdy = 1'b1;
        v.e_valid = ev; v.e_data = ed; v.e_sop = es; v.e_eop = ee; v.e_rdreq = er; v.e_busy = eb;
        return v;
    endfunction

    // Showahead FIFO: pop on rdreq, push on wr_en, flags visible after the edge.
    always @(posedge clk) begin
        if (srst) begin
            fq.delete();
        end else begin
            if (fifo_rdreq && fq.size() > 0) void'(fq.pop_front());
            if (wr_en) fq.push_back(wr_data);
        end
        fifo_empty <= (fq.size() == 0);
        fifo_usedw <= (AWIDTH+1)'(fq.size());
        fifo_q     <= (fq.size() > 0) ? fq[0] : '0;
    end

    // Stream scoreboard: FIFO order, framing, stall stability, pop legality.
    initial begin
        logic              prev_stall = 1'b0;
        logic [DWIDTH-1:0] pd = '0;
        logic              ps = 1'b0;
        logic              pe = 1'b0;
        logic              in_burst = 1'b0;
        int                blen = 0;
        logic [DWIDTH-1:0] w;
        forever begin
            @(negedge clk);
            #2;
            if (srst) begin
                exp_q.delete();
                prev_stall = 1'b0;
                in_burst   = 1'b0;
                blen       = 0;
            end else begin
                if (prev_stall) begin
                    chk("stall valid", valid, 1'b1);
                    chk("stall data", data, pd);
                    chk("stall sop", sop, ps);
                    chk("stall eop", eop, pe);
                end
                if (fifo_rdreq) chk("pop while empty", fifo_empty, 1'b0);
                if (valid && !ready) chk("pop while stalled", fifo_rdreq, 1'b0);
                if (valid && eop && !prev_stall) chk("idle gap after burst", fifo_rdreq, 1'b0);
                if (valid && ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("word with nothing written");
                    end else begin
                        w = exp_q.pop_front();
                        chk("word order", data, w);
                    end
                    chk("sop framing", sop, !in_burst);
                    in_burst = 1'b1;
                    blen++;
                    if (eop) begin
                        chk("burst length max", blen <= BURST_LEN, 1'b1);
                        last_len = blen;
                        nbursts++;
                        in_burst = 1'b0;
                        blen     = 0;
                    end
                end
                prev_stall = valid && !ready;
                pd = data;
                ps = sop;
                pe = eop;
                if (wr_en) exp_q.push_back(wr_data);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (z_watch && !srst && (z_rdreq || z_valid)) z_seen = 1'b1;
        end
    end

    initial begin
        int sop_k[$];
        int eop_k[$];
        int n0;
        int stalls;
        logic [6:0] pat;
        logic found;
        logic z_got, z_gs, z_ge, z_popped;
        logic [DWIDTH-1:0] z_gd;

        // Reset state
        srst = 1'b1;
        repeat (3) cyc(1'b1, 1'b0, 1'b0, '0);
        chk("reset valid", valid, 1'b0);
        chk("reset sop", sop, 1'b0);
        chk("reset eop", eop, 1'b0);
        chk("reset data", data, 4'h0);
        chk("reset busy", busy, 1'b0);
        chk("reset rdreq", fifo_rdreq, 1'b0);
        srst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, '0);

        // Single full burst, cycle by cycle
        tv[0]  = mk(1'b1, 4'hA, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tv[1]  = mk(1'b1, 4'hB, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tv[2]  = mk(1'b1, 4'hC, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tv[3]  = mk(1'b1, 4'hD, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tv[4]  = mk(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tv[5]  = mk(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        tv[6]  = mk(1'b0, 4'h0, 1'b1, 4'hA, 1'b1, 1'b0, 1'b1, 1'b1);
        tv[7]  = mk(1'b0, 4'h0, 1'b1, 4'hB, 1'b0, 1'b0, 1'b1, 1'b1);
        tv[8]  = mk(1'b0, 4'h0, 1'b1, 4'hC, 1'b0, 1'b0, 1'b1, 1'b1);
        tv[9]  = mk(1'b0, 4'h0, 1'b1, 4'hD, 1'b0, 1'b1, 1'b0, 1'b1);
        tv[10] = mk(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            cyc(tv[i].rdy, 1'b0, tv[i].wr, tv[i].wd);
            chk($sformatf("t1[%0d] valid", i), valid, tv[i].e_valid);
            chk($sformatf("t1[%0d] rdreq", i), fifo_rdreq, tv[i].e_rdreq);
            chk($sformatf("t1[%0d] busy", i), busy, tv[i].e_busy);
            if (tv[i].e_valid) begin
                chk($sformatf("t1[%0d] data", i), data, tv[i].e_data);
                chk($sformatf("t1[%0d] sop", i), sop, tv[i].e_sop);
                chk($sformatf("t1[%0d] eop", i), eop, tv[i].e_eop);
            end
        end
        repeat (3) cyc(1'b1, 1'b0, 1'b0, '0);

        // 10 words: two full bursts, then a timeout flush of the last two
        for (int k = 0; k < 30; k++) begin
            cyc(1'b1, 1'b0, k < 10, DWIDTH'(k + 1));
            if (valid && sop) sop_k.push_back(k);
            if (valid && eop) eop_k.push_back(k);
        end
        chk("t2 sop count", sop_k.size(), 3);
        chk("t2 eop count", eop_k.size(), 3);
        if (sop_k.size() == 3) begin
            chk("t2 sop0 cycle", sop_k[0], 6);
            chk("t2 sop1 cycle", sop_k[1], 11);
            chk("t2 sop2 cycle (timeout)", sop_k[2], 23);
        end
        if (eop_k.size() == 3) begin
            chk("t2 eop0 cycle", eop_k[0], 9);
            chk("t2 eop1 cycle", eop_k[1], 14);
            chk("t2 eop2 cycle (timeout)", eop_k[2], 24);
        end
        repeat (3) cyc(1'b1, 1'b0, 1'b0, '0);

        // One word flushed by request, long before the timeout
        cyc(1'b1, 1'b0, 1'b1, 4'h5);
        cyc(1'b1, 1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk("t3 rdreq early", fifo_rdreq, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk("t3 rdreq", fifo_rdreq, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk("t3 valid", valid, 1'b1);
        chk("t3 sop", sop, 1'b1);
        chk("t3 eop", eop, 1'b1);
        chk("t3 data", data, 4'h5);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, '0);

        // Back-pressure during a full burst
        cyc(1'b1, 1'b0, 1'b1, 4'h3);
        cyc(1'b1, 1'b0, 1'b1, 4'h8);
        cyc(1'b1, 1'b0, 1'b1, 4'hE);
        cyc(1'b1, 1'b0, 1'b1, 4'h0);
        n0     = nbursts;
        stalls = 0;
        pat    = 7'b1001011;
        for (int i = 0; i < 7; i++) begin
            cyc(pat[6-i], 1'b0, 1'b0, '0);
            if (valid && !ready) stalls++;
        end
        for (int i = 0; i < 20 && nbursts == n0; i++) cyc(1'b1, 1'b0, 1'b0, '0);
        chk("t4 stall cycles", stalls, 2);
        chk("t4 bursts", nbursts - n0, 1);
        chk("t4 burst length", last_len, 4);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, '0);

        // Reset in the middle of a burst, then a fresh burst
        cyc(1'b1, 1'b0, 1'b1, 4'h6);
        cyc(1'b1, 1'b0, 1'b1, 4'h7);
        cyc(1'b1, 1'b0, 1'b1, 4'h8);
        cyc(1'b1, 1'b0, 1'b1, 4'h9);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc(1'b1, 1'b0, 1'b0, '0);
            if (valid && data == 4'h7) found = 1'b1;
        end
        if (!found) fail_now("t5 second word");
        @(negedge clk); srst = 1'b1; #1;
        @(negedge clk); srst = 1'b0; #1;
        chk("t5 valid after reset", valid, 1'b0);
        chk("t5 busy after reset", busy, 1'b0);
        chk("t5 rdreq after reset", fifo_rdreq, 1'b0);
        n0 = nbursts;
        cyc(1'b1, 1'b0, 1'b1, 4'hB);
        cyc(1'b1, 1'b0, 1'b1, 4'hC);
        cyc(1'b1, 1'b0, 1'b1, 4'hD);
        cyc(1'b1, 1'b0, 1'b1, 4'hE);
        for (int i = 0; i < 20 && nbursts == n0; i++) cyc(1'b1, 1'b0, 1'b0, '0);
        chk("t5 bursts after reset", nbursts - n0, 1);
        chk("t5 burst length", last_len, 4);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, '0);

        // Flush with an empty FIFO is dropped
        cyc(1'b1, 1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        n0 = nbursts;
        cyc(1'b1, 1'b0, 1'b1, 4'h1);
        cyc(1'b1, 1'b0, 1'b1, 4'h2);
        cyc(1'b1, 1'b0, 1'b1, 4'h4);
        cyc(1'b1, 1'b0, 1'b1, 4'hF);
        repeat (20) cyc(1'b1, 1'b0, 1'b0, '0);
        chk("t6 bursts", nbursts - n0, 1);
        chk("t6 burst length", last_len, 4);

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 3,
                ($urandom_range(0, 99) < 40) && (fifo_usedw < 120), DWIDTH'($urandom));
        end
        for (int i = 0; i < 600 && (exp_q.size() != 0 || busy); i++) cyc(1'b1, 1'b0, 1'b0, '0);
        chk("random drain words left", exp_q.size(), 0);
        chk("random drain busy", busy, 1'b0);

        // Timeout disabled: the lone word waits until a flush
        chk("t0 word held", z_seen, 1'b0);
        z_watch  = 1'b0;
        z_got    = 1'b0;
        z_gs     = 1'b0;
        z_ge     = 1'b0;
        z_gd     = '0;
        z_popped = 1'b0;
        @(negedge clk); z_flush = 1'b1; #1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            z_flush = 1'b0;
            if (z_popped) z_empty = 1'b1;
            #1;
            if (z_rdreq) z_popped = 1'b1;
            if (z_valid && !z_got) begin
                z_got = 1'b1; z_gs = z_sop; z_ge = z_eop; z_gd = z_data;
            end
        end
        chk("t0 flushed", z_got, 1'b1);
        chk("t0 sop", z_gs, 1'b1);
        chk("t0 eop", z_ge, 1'b1);
        chk("t0 data", z_gd, 4'h5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Downstream consumer of the team's showahead FIFO.
- Drains the FIFO through its q/empty/usedw/rdreq interface and emits framed bursts on a valid/ready stream, with sop/eop markers.
- Starts a full burst of BURST_LEN words once enough words are buffered.
- Flushes a partial burst after an idle timeout or on request, so trailing words never stall.

Parameters:
- DWIDTH, 4, data width; must match the FIFO.
- AWIDTH, 7, FIFO address width; usedw is AWIDTH+1 bits.
- BURST_LEN, 4, words per full burst; legal range 1..2^AWIDTH.
- TIMEOUT, 8, idle cycles before a partial flush; 0 disables the timeout flush.

Ports:
- clk_i  in  1  clock.
- srst_i  in  1  reset: synchronous, active-high.
- fifo_q_i  in  DWIDTH  FIFO showahead data; valid when fifo_empty_i=0.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_usedw_i  in  AWIDTH+1  FIFO fill level.
- fifo_rdreq_o  out  1  pop request to the FIFO.
- flush_i  in  1  single-cycle request to send buffered words as a partial burst now.
- data_o  out  DWIDTH  stream data.
- valid_o  out  1  stream valid.
- ready_i  in  1  stream ready.
- sop_o  out  1  first word of a burst; qualified by valid_o.
- eop_o  out  1  last word of a burst; qualified by valid_o.
- busy_o  out  1  high while in RUN or while valid_o=1.

Behaviour:
- Reset values: valid_o=0, sop_o=0, eop_o=0, data_o=0, busy_o=0, fifo_rdreq_o=0. State=IDLE, timer=0, remaining=0, flush_pending=0.
- Output register: holds data_o, sop_o and eop_o together.
  - load = !valid_o | ready_i.
  - fifo_rdreq_o = (state==RUN) & load & !fifo_empty_i. This is a combinational path from ready_i; it is allowed.
  - On a cycle with fifo_rdreq_o=1: next cycle data_o=fifo_q_i and valid_o=1; sop_o=1 if this is the first pop of the burst; eop_o=1 if remaining==1.
  - On load without a pop: next cycle valid_o=0.
  - The output holds stable while valid_o & !ready_i.
- Latency: FIFO word visible -> on data_o the next cycle.
- State IDLE:
  - fifo_usedw_i >= BURST_LEN -> RUN, remaining=BURST_LEN.
  - Else if !fifo_empty_i and (flush_pending or (TIMEOUT!=0 and timer==TIMEOUT-1)) -> RUN, remaining=fifo_usedw_i (captured value, never 0). Clear flush_pending.
  - Full-burst rule has priority over a flush in the same cycle.
- State RUN:
  - remaining decrements on each pop.
  - The pop with remaining==1 returns to IDLE the next cycle.
  - No IDLE->RUN transition in that same cycle; at least one IDLE cycle occurs between bursts.
- Timer:
  - Counts cycles in IDLE while !fifo_empty_i.
  - Clears on entering RUN, when fifo_empty_i=1, or on srst_i.
  - Saturates at TIMEOUT-1.
- flush_i:
  - Sets flush_pending when asserted in any state.
  - Served on the next IDLE cycle with the FIFO non-empty.
  - Dropped silently if the FIFO is empty in IDLE.
- Starvation guard: burst length never exceeds usedw captured at start, and this block is the FIFO's only reader, so RUN never sees empty. If fifo_empty_i=1 in RUN anyway, rdreq stays 0 and the block waits; remaining is unchanged.
- Widths: remaining and timer are AWIDTH+1 bits. No wrap; all comparisons are unsigned.
- Back-pressure: ready_i=0 mid-burst stalls pops; no word is lost or duplicated; sop/eop stay attached to the correct words.
- Reset mid-burst: all state and outputs return to reset values next cycle; the partial burst is abandoned with no eop. The FIFO is reset by the same srst_i.
- Output words appear in exact FIFO order across bursts.

Test Plan:
- Reset, then write 4 words A,B,C,D with ready_i=1 -> one burst of A..D on 4 consecutive valid cycles; sop with A, eop with D; rdreq high exactly 4 cycles.
- Write 10 words, ready_i=1 -> bursts of 4 and 4, each separated by at least 1 IDLE cycle. Remaining 2 words sent as a partial burst (sop+eop framing) exactly TIMEOUT=8 idle cycles after the FIFO stops being written.
- Write 1 word, pulse flush_i one cycle later -> burst of length 1 with sop=eop=1, before the timeout expires; TIMEOUT=0 with no flush -> the word is held indefinitely.
- 4-word burst with ready_i toggling 1,0,0,1,0,1,1 -> data_o, sop and eop stable while stalled; 4 words delivered in order, no pops while ready_i=0 & valid_o=1.
- Assert srst_i after the 2nd word of a 4-word burst -> next cycle valid_o=0, busy_o=0, fifo_rdreq_o=0; the new burst after refill starts with sop.
- flush_i with the FIFO empty, then write 4 words -> a single full burst of 4; no spurious length-0 burst.
